// File: rtl/irq_pkg.sv
// Shared types and default parameters for the interrupt dispatch unit.
// Imported by irq_dispatch_unit; holds the FSM state type.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_disp_state_t;

  localparam int IRQ_N_DEFAULT           = 8;
  localparam int IRQ_ACK_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/irq_dispatch_unit.sv
// CPU-side responder for a fixed-priority interrupt controller.
// Latches the winning ID, offers it to the CPU over req/ack, tracks
// the in-service line until EOI and pulses a clear back to the source.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   irq_valid, irq_id     controller winner
//   cpu_irq, cpu_vector   request to CPU (vector stable while irq=1)
//   cpu_ack               CPU accepts request (pulse)
//   cpu_eoi, cpu_eoi_id   end-of-interrupt strobe and ID
//   irq_clear             one-hot, one-cycle source clear pulse
//   in_service            one-hot in-service line (mask feedback)
//   timeout_err           pulse: request dropped without ack
//   spurious_eoi          pulse: EOI not matching in-service ID
// All outputs are registered.
module irq_dispatch_unit
  import irq_pkg::*;
#(
  parameter int N           = IRQ_N_DEFAULT,
  parameter int ACK_TIMEOUT = IRQ_ACK_TIMEOUT_DEFAULT,
  localparam int IDW        = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           irq_valid,
  input  logic [IDW-1:0] irq_id,
  output logic           cpu_irq,
  output logic [IDW-1:0] cpu_vector,
  input  logic           cpu_ack,
  input  logic           cpu_eoi,
  input  logic [IDW-1:0] cpu_eoi_id,
  output logic [N-1:0]   irq_clear,
  output logic [N-1:0]   in_service,
  output logic           timeout_err,
  output logic           spurious_eoi
);

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);
  localparam logic [IDW:0] N_L = (IDW + 1)'(N);
  localparam logic [N-1:0] ONE = {{(N - 1){1'b0}}, 1'b1};

  irq_disp_state_t state_q;
  logic [TW-1:0]   timer_q;
  logic [IDW-1:0]  vec_q;
  logic            cpu_irq_q;
  logic [N-1:0]    irq_clear_q;
  logic [N-1:0]    in_service_q;
  logic            timeout_q;
  logic            spurious_q;

  logic            id_ok;
  logic [N-1:0]    id_oh;
  logic [N-1:0]    vec_oh;
  logic            accept;
  logic            eoi_hit;

  // IDs past the last line (non power-of-2 N) count as no request.
  assign id_ok   = {1'b0, irq_id} < N_L;
  assign id_oh   = id_ok ? (ONE << irq_id) : '0;
  assign vec_oh  = ONE << vec_q;
  assign accept  = irq_valid && id_ok &&
                   ((in_service_q & id_oh) == '0);
  assign eoi_hit = cpu_eoi && (cpu_eoi_id == vec_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      vec_q        <= '0;
      cpu_irq_q    <= 1'b0;
      irq_clear_q  <= '0;
      in_service_q <= '0;
      timeout_q    <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      irq_clear_q <= '0;
      timeout_q   <= 1'b0;
      spurious_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          spurious_q <= cpu_eoi;
          if (accept) begin
            vec_q     <= irq_id;
            timer_q   <= '0;
            cpu_irq_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          spurious_q <= cpu_eoi;
          // Ack is checked first so it beats a same-cycle timeout.
          if (cpu_ack) begin
            cpu_irq_q    <= 1'b0;
            in_service_q <= vec_oh;
            irq_clear_q  <= vec_oh;
            state_q      <= SERVICE;
          end else if (timer_q == TMAX) begin
            cpu_irq_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        SERVICE: begin
          if (eoi_hit) begin
            in_service_q <= '0;
            state_q      <= IDLE;
          end else if (cpu_eoi) begin
            spurious_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_irq      = cpu_irq_q;
  assign cpu_vector   = vec_q;
  assign irq_clear    = irq_clear_q;
  assign in_service   = in_service_q;
  assign timeout_err  = timeout_q;
  assign spurious_eoi = spurious_q;

  a_insvc_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(in_service_q));

  a_clear_single: assert property (
    @(posedge clk) disable iff (!rst_n)
    (irq_clear_q != '0) |=> (irq_clear_q == '0));

endmodule

// File: tb/tb_irq_dispatch_unit.sv
// Bench for irq_dispatch_unit: vector table, directed
// timeout/reset sequences and a randomized reference model.
module tb_irq_dispatch_unit;

  localparam int N   = 8;
  localparam int TO  = 16;
  localparam int IDW = 3;

  logic           clk;
  logic           rst_n;
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic           cpu_irq;
  logic [IDW-1:0] cpu_vector;
  logic           cpu_ack;
  logic           cpu_eoi;
  logic [IDW-1:0] cpu_eoi_id;
  logic [N-1:0]   irq_clear;
  logic [N-1:0]   in_service;
  logic           timeout_err;
  logic           spurious_eoi;

  int tests;
  int fails;

  irq_dispatch_unit #(.N(N), .ACK_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_valid    (irq_valid),
    .irq_id       (irq_id),
    .cpu_irq      (cpu_irq),
    .cpu_vector   (cpu_vector),
    .cpu_ack      (cpu_ack),
    .cpu_eoi      (cpu_eoi),
    .cpu_eoi_id   (cpu_eoi_id),
    .irq_clear    (irq_clear),
    .in_service   (in_service),
    .timeout_err  (timeout_err),
    .spurious_eoi (spurious_eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           valid;
    logic [IDW-1:0] id;
    logic           ack;
    logic           eoi;
    logic [IDW-1:0] eid;
    logic [21:0]    exp;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [21:0] outs();
    return {cpu_irq, cpu_vector, irq_clear,
            in_service, timeout_err, spurious_eoi};
  endfunction

  function automatic logic [21:0] mk(
    logic i, logic [2:0] v, logic [7:0] c,
    logic [7:0] s, logic t, logic p);
    return {i, v, c, s, t, p};
  endfunction

  function automatic vec_t row(
    logic va, logic [2:0] id, logic ak,
    logic eo, logic [2:0] ei, logic [21:0] e);
    vec_t r;
    r.valid = va; r.id = id; r.ack = ak;
    r.eoi = eo; r.eid = ei; r.exp = e;
    return r;
  endfunction

  task automatic check(string name,
                       logic [63:0] got,
                       logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    irq_valid = 0; irq_id = 0; cpu_ack = 0;
    cpu_eoi = 0; cpu_eoi_id = 0;
  endtask

  // Reference model state: spec-level view of the dispatcher.
  bit m_req;
  int m_vec;
  int m_svc;
  int m_vis;
  logic [21:0] m_exp;

  task automatic model_step();
    logic [7:0] clr;
    logic to, sp;
    clr = 0; to = 0; sp = 0;
    if (m_svc >= 0) begin
      if (cpu_eoi) begin
        if (int'(cpu_eoi_id) == m_svc) m_svc = -1;
        else sp = 1;
      end
    end else if (m_req) begin
      sp = cpu_eoi;
      if (cpu_ack) begin
        m_svc = m_vec;
        m_req = 0;
        clr = 8'(1 << m_vec);
      end else if (m_vis == TO) begin
        m_req = 0;
        to = 1;
      end else begin
        m_vis++;
      end
    end else begin
      sp = cpu_eoi;
      if (irq_valid) begin
        m_req = 1;
        m_vec = int'(irq_id);
        m_vis = 1;
      end
    end
    m_exp = {m_req, 3'(m_vec), clr,
             (m_svc >= 0) ? 8'(1 << m_svc) : 8'h00,
             to, sp};
  endtask

  initial begin
    int hi;
    logic saw_to;
    logic clr_seen;
    tests = 0;
    fails = 0;
    idle_in();
    rst_n = 0;

    tbl[0]  = row(1, 5, 0, 0, 0, mk(1, 5, 8'h00, 8'h00, 0, 0));
    tbl[1]  = row(0, 0, 0, 0, 0, mk(1, 5, 8'h00, 8'h00, 0, 0));
    tbl[2]  = row(0, 0, 1, 0, 0, mk(0, 5, 8'h20, 8'h20, 0, 0));
    tbl[3]  = row(0, 0, 0, 0, 0, mk(0, 5, 8'h00, 8'h20, 0, 0));
    tbl[4]  = row(1, 6, 0, 0, 0, mk(0, 5, 8'h00, 8'h20, 0, 0));
    tbl[5]  = row(1, 6, 0, 1, 3, mk(0, 5, 8'h00, 8'h20, 0, 1));
    tbl[6]  = row(1, 6, 0, 1, 5, mk(0, 5, 8'h00, 8'h00, 0, 0));
    tbl[7]  = row(1, 6, 0, 0, 0, mk(1, 6, 8'h00, 8'h00, 0, 0));
    tbl[8]  = row(0, 0, 0, 1, 0, mk(1, 6, 8'h00, 8'h00, 0, 1));
    tbl[9]  = row(0, 0, 1, 0, 0, mk(0, 6, 8'h40, 8'h40, 0, 0));
    tbl[10] = row(0, 0, 1, 0, 0, mk(0, 6, 8'h00, 8'h40, 0, 0));
    tbl[11] = row(0, 0, 0, 1, 6, mk(0, 6, 8'h00, 8'h00, 0, 0));
    tbl[12] = row(0, 0, 0, 1, 6, mk(0, 6, 8'h00, 8'h00, 0, 1));
    tbl[13] = row(0, 0, 0, 0, 0, mk(0, 6, 8'h00, 8'h00, 0, 0));
    tbl[14] = row(1, 7, 0, 0, 0, mk(1, 7, 8'h00, 8'h00, 0, 0));
    tbl[15] = row(0, 0, 1, 0, 0, mk(0, 7, 8'h80, 8'h80, 0, 0));
    tbl[16] = row(0, 0, 0, 1, 3, mk(0, 7, 8'h00, 8'h80, 0, 1));
    tbl[17] = row(0, 0, 0, 1, 7, mk(0, 7, 8'h00, 8'h00, 0, 0));

    tick();
    tick();
    check("reset_state", 64'(outs()), 64'h0);
    #2 rst_n = 1;
    tick();

    for (int i = 0; i < 18; i++) begin
      irq_valid  = tbl[i].valid;
      irq_id     = tbl[i].id;
      cpu_ack    = tbl[i].ack;
      cpu_eoi    = tbl[i].eoi;
      cpu_eoi_id = tbl[i].eid;
      tick();
      check($sformatf("table_row%0d", i),
            64'(outs()), 64'(tbl[i].exp));
    end
    idle_in();
    tick();

    // Timeout with irq_valid held high.
    irq_valid = 1; irq_id = 2;
    tick();
    check("to_first_irq", 64'({cpu_irq, cpu_vector}),
          64'({1'b1, 3'd2}));
    hi = 1; saw_to = 0; clr_seen = 0;
    for (int k = 0; k < 40 && cpu_irq; k++) begin
      tick();
      clr_seen |= |irq_clear;
      if (cpu_irq) hi++;
      else saw_to = timeout_err;
    end
    check("to_irq_cycles", 64'(hi), 64'(TO));
    check("to_err_pulse", 64'(saw_to), 64'h1);
    check("to_no_clear", 64'(clr_seen), 64'h0);
    tick();
    check("to_rearb", 64'({cpu_irq, cpu_vector, timeout_err}),
          64'({1'b1, 3'd2, 1'b0}));

    // Ack on the last permitted cycle beats the timeout.
    irq_valid = 0;
    for (int k = 0; k < TO - 1; k++) tick();
    check("tie_still_req", 64'(cpu_irq), 64'h1);
    cpu_ack = 1;
    tick();
    cpu_ack = 0;
    check("tie_ack_wins",
          64'({cpu_irq, irq_clear, in_service, timeout_err}),
          64'({1'b0, 8'h04, 8'h04, 1'b0}));
    tick();
    check("tie_no_late_to", 64'(timeout_err), 64'h0);
    cpu_eoi = 1; cpu_eoi_id = 2;
    tick();
    cpu_eoi = 0;
    check("tie_eoi", 64'(in_service), 64'h0);

    // Async reset mid-REQ.
    irq_valid = 1; irq_id = 4;
    tick();
    irq_valid = 0;
    check("rst_req_setup", 64'(cpu_irq), 64'h1);
    #2 rst_n = 0;
    #1 check("rst_mid_req", 64'(outs()), 64'h0);
    #1 rst_n = 1;
    tick();
    check("rst_req_after", 64'(outs()), 64'h0);

    // Async reset mid-SERVICE.
    irq_valid = 1; irq_id = 1;
    tick();
    irq_valid = 0;
    check("rst_resume", 64'({cpu_irq, cpu_vector}),
          64'({1'b1, 3'd1}));
    cpu_ack = 1;
    tick();
    cpu_ack = 0;
    check("rst_svc_setup", 64'(in_service), 64'h02);
    #2 rst_n = 0;
    #1 check("rst_mid_svc", 64'(outs()), 64'h0);
    #1 rst_n = 1;
    tick();
    check("rst_svc_after", 64'(outs()), 64'h0);

    // Randomized run against the reference model.
    m_req = 0; m_vec = 0; m_svc = -1; m_vis = 0;
    for (int c = 0; c < 3000; c++) begin
      irq_valid = ($urandom_range(1) == 1);
      irq_id    = 3'($urandom_range(N - 1));
      cpu_ack   = ($urandom_range(11) == 0);
      cpu_eoi   = ($urandom_range(4) == 0);
      if (m_svc >= 0 && $urandom_range(1) == 1)
        cpu_eoi_id = 3'(m_svc);
      else
        cpu_eoi_id = 3'($urandom_range(N - 1));
      model_step();
      tick();
      check($sformatf("rand_c%0d", c),
            64'(outs()), 64'(m_exp));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
